// File: rtl/axis_egress_framed.sv
// Purpose : AXI4-Stream egress stage; frame-aligned metadata from a FIFO, registered 2-entry skid buffer.
// Latency : 1 cycle from input acceptance to m_axis valid; metadata is poppable 1 cycle after its write.
// Backpr. : absorbs 2 beats when m_axis_tready is low; s_axis_tready drops the cycle after the buffer fills.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   s_axis_*              input stream (tdata/tkeep/tvalid/tready/tlast)
//   meta_in/meta_valid_in metadata write strobe, one entry per frame, no backpressure
//   m_axis_*              registered output stream
//   m_meta, m_meta_sof    metadata of the frame on m_axis, first-beat marker
//   meta_overflow         sticky dropped-metadata flag, cleared by clear_status
//   frame_count           frames completed on m_axis (tlast accepted), wraps

typedef struct packed {
    logic [15:0] ethertype;
    logic [11:0] vlan_id;
    logic [3:0]  flags;
} eth_metadata_t;

module axis_egress_framed #(
    parameter int DATA_WIDTH = 64,
    parameter int KEEP_WIDTH = DATA_WIDTH / 8,
    parameter int META_WIDTH = $bits(eth_metadata_t),
    parameter int META_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [KEEP_WIDTH-1:0] s_axis_tkeep,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    input  logic                  s_axis_tlast,
    input  logic [META_WIDTH-1:0] meta_in,
    input  logic                  meta_valid_in,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tlast,
    output logic [META_WIDTH-1:0] m_meta,
    output logic                  m_meta_sof,
    output logic                  meta_overflow,
    input  logic                  clear_status,
    output logic [31:0]           frame_count
);

    localparam int PTR_W = $clog2(META_DEPTH);
    localparam int ENT_W = DATA_WIDTH + KEEP_WIDTH + 1 + META_WIDTH + 1;
    localparam logic [PTR_W:0] DEPTH_V = META_DEPTH[PTR_W:0];

    localparam logic [0:0] ST_SOF  = 1'b0;
    localparam logic [0:0] ST_BODY = 1'b1;

    // metadata FIFO
    logic [META_WIDTH-1:0] fifo_mem [META_DEPTH];
    logic [PTR_W-1:0]      wr_idx;
    logic [PTR_W-1:0]      rd_idx;
    logic [PTR_W:0]        fifo_cnt;
    logic [PTR_W:0]        fifo_cnt_nxt;
    logic                  fifo_empty;
    logic                  fifo_full;
    logic                  fifo_push;
    logic                  fifo_pop;
    logic                  meta_drop;

    // input framing
    logic [0:0]            state;
    logic [META_WIDTH-1:0] meta_lat;
    logic [META_WIDTH-1:0] tag_meta;
    logic                  in_acc;

    // skid buffer: out_ent drives m_axis, skid_ent holds the overflow beat
    logic [ENT_W-1:0]      in_ent;
    logic [ENT_W-1:0]      out_ent;
    logic [ENT_W-1:0]      skid_ent;
    logic                  out_vld;
    logic                  skid_vld;
    logic                  skid_vld_nxt;
    logic                  out_vld_nxt;
    logic                  skid_not_full;
    logic                  out_stall;

    assign s_axis_tready = skid_not_full & ((state == ST_BODY) | ~fifo_empty);
    assign in_acc        = s_axis_tvalid & s_axis_tready;

    assign fifo_pop  = in_acc & (state == ST_SOF);
    // A full FIFO still takes a write when the head leaves in the same cycle.
    assign fifo_push = meta_valid_in & (~fifo_full | fifo_pop);
    assign meta_drop = meta_valid_in & fifo_full & ~fifo_pop;
    assign fifo_cnt_nxt = fifo_cnt + {{PTR_W{1'b0}}, fifo_push} - {{PTR_W{1'b0}}, fifo_pop};

    assign tag_meta = (state == ST_SOF) ? fifo_mem[rd_idx] : meta_lat;
    assign in_ent   = {s_axis_tdata, s_axis_tkeep, s_axis_tlast, tag_meta, (state == ST_SOF)};

    assign out_stall    = out_vld & ~m_axis_tready;
    // skid_not_full is taken from the next-state skid occupancy so tready stays a flop output.
    assign skid_vld_nxt = out_stall & (skid_vld | in_acc);
    assign out_vld_nxt  = skid_vld | in_acc | out_stall;

    assign {m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_meta, m_meta_sof} = out_ent;
    assign m_axis_tvalid = out_vld;

    always_ff @(posedge clk) begin
        if (fifo_push) begin
            fifo_mem[wr_idx] <= meta_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_idx        <= '0;
            rd_idx        <= '0;
            fifo_cnt      <= '0;
            fifo_empty    <= 1'b1;
            fifo_full     <= 1'b0;
            meta_overflow <= 1'b0;
        end else begin
            if (fifo_push) wr_idx <= wr_idx + 1'b1;
            if (fifo_pop)  rd_idx <= rd_idx + 1'b1;
            fifo_cnt   <= fifo_cnt_nxt;
            fifo_empty <= (fifo_cnt_nxt == '0);
            fifo_full  <= (fifo_cnt_nxt == DEPTH_V);
            if (meta_drop) begin
                meta_overflow <= 1'b1;
            end else if (clear_status) begin
                meta_overflow <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_SOF;
            meta_lat <= '0;
        end else begin
            if (fifo_pop) meta_lat <= fifo_mem[rd_idx];
            if (in_acc)   state    <= s_axis_tlast ? ST_SOF : ST_BODY;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_ent       <= '0;
            skid_ent      <= '0;
            out_vld       <= 1'b0;
            skid_vld      <= 1'b0;
            skid_not_full <= 1'b0;
        end else begin
            if (!out_stall) begin
                // Output register is free: the older skid beat goes first.
                if (skid_vld) begin
                    out_ent <= skid_ent;
                end else if (in_acc) begin
                    out_ent <= in_ent;
                end
            end else if (in_acc) begin
                skid_ent <= in_ent;
            end
            out_vld       <= out_vld_nxt;
            skid_vld      <= skid_vld_nxt;
            skid_not_full <= ~skid_vld_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_count <= '0;
        end else if (m_axis_tvalid & m_axis_tready & m_axis_tlast) begin
            frame_count <= frame_count + 32'd1;
        end
    end

endmodule
